sequenciador_acoes: RTL
=======================

// Module: sequenciador_acoes
// PURPOSE
//  Controller that sequences the dog toy's action index. Produces the 3-bit action code consumed by the action
//  display logic from power switch, speed switches (chave1/chave2) and the pushbutton.
//  Replaces the free-running clock-select + counter path with one synchronous FSM on the board clock.
//  Supports auto-run at 3 speeds, pause/resume via button, and a manual single-step mode.
// PARAMETERS
//  TICK_DIV        50_000_000/8  clock_entrada cycles per base tick (>=2)
//  NUM_ACOES       6             number of actions; acoes wraps NUM_ACOES-1 -> 0 (2..8)
//  DEBOUNCE_CYCLES 500_000       cycles botao_in must be stable before a new level is accepted (>=1)
// PORTS
//  clock_entrada  in   1  board clock; all state changes on its rising edge
//  reset          in   1  asynchronous, active-high reset
//  power          in   1  power switch, 1 = on; raw, async to clock
//  botao_in       in   1  pushbutton, active-low (0 = pressed); raw, bouncing
//  chave1         in   1  speed select LSB; raw
//  chave2         in   1  speed select MSB; raw
//  acoes          out  3  current action index, registered
//  velocidade     out  2  registered, synchronized speed code {chave2,chave1}
//  estado         out  2  FSM state code, registered
//  passo          out  1  one-cycle pulse, high in the same cycle acoes takes its new value
// BEHAVIOUR
//  Reset (async, active-high): acoes=0, velocidade=00, estado=DESLIGADO, passo=0, all counters/synchronizers=0.
//  Input sync: power, chave1, chave2 and botao_in each pass a 2-FF synchronizer. Logic below uses synced values.
//  Debounce: botao synced level accepted only after DEBOUNCE_CYCLES consecutive equal samples.
//   press = accepted level 1->0, a single-cycle event. Release generates nothing.
//  Speed code spd = velocidade: 00 -> advance every 4 base ticks; 01 -> every 2; 10 -> every 1; 11 -> manual.
//  Base counter: counts 0..TICK_DIV-1 in RODANDO only; base_tick on terminal count.
//   Step counter counts base_ticks up to N(spd)-1; advance on its terminal count with base_tick.
//  Advance: acoes <= (acoes==NUM_ACOES-1) ? 0 : acoes+1; passo=1 that cycle.
//  States (estado code): DESLIGADO=00, RODANDO=01, PAUSADO=10, MANUAL=11.
//   DESLIGADO: acoes held at 0; counters cleared; presses ignored. power=1 -> MANUAL if spd==11, else RODANDO.
//   RODANDO: counters run; press -> PAUSADO (counters freeze at current values); spd becomes 11 -> MANUAL.
//   PAUSADO: acoes and counters frozen; press -> RODANDO (resume from frozen counts). spd changes update
//    velocidade and clear step counter, but the state stays PAUSADO.
//   MANUAL: counters cleared; each press = one advance. spd leaves 11 -> RODANDO with counters from 0.
//  Priority per cycle: power=0 (any state -> DESLIGADO, acoes<=0 next edge) > spd change > press > tick.
//   press and advance tick in same RODANDO cycle: pause wins, no advance, passo=0.
//   spd change in same cycle as tick: tick discarded; step counter cleared, base counter kept.
//   press arriving with power=0: discarded, not remembered.
//  Latency: raw botao_in edge -> press = 2 sync + DEBOUNCE_CYCLES cycles; estado/acoes update on next edge.
//   power change -> estado change = 3 edges (2 sync + 1 FSM).
//  Widths: base counter $clog2(TICK_DIV); step counter 2 bits; acoes 3 bits, never >= NUM_ACOES.
//  passo never high in DESLIGADO or PAUSADO; never high for two consecutive cycles in MANUAL.
// STRUCTURE
//  Shared package brinquedo_pkg:
//   - estado codes (DESLIGADO/RODANDO/PAUSADO/MANUAL)
//   - speed codes and their N(spd) step counts
//   - NUM_ACOES default
//  Sub-module debounce_botao: 2-FF sync + stability counter + falling-edge detector.
//   Ports: clock_entrada, reset, botao_in, press; parameter DEBOUNCE_CYCLES.
//  Top keeps the remaining synchronizers, the base/step counters and the FSM.
// TESTING (bench: TICK_DIV=4, NUM_ACOES=6, DEBOUNCE_CYCLES=3)
//  1 reset=1 with power=1 -> acoes=0, estado=00, passo=0; reset=0, spd=10 -> estado=01 by edge 3,
//    first passo 4 base-clock cycles later, acoes 1,2,..5,0 wrap.
//  2 spd=00 running -> passo every 16 cycles. Switch to 01 mid-count -> next passo <=8 cycles after
//    velocidade updates, then every 8.
//  3 clean press while RODANDO -> estado=10 at edge 2+3+1, acoes frozen 100 cycles.
//    Second press -> estado=01, next passo after remaining frozen count.
//  4 spd=11 -> estado=11; 3 presses with bounce (toggle every cycle x2, then hold 5) -> acoes +3 exactly,
//    3 passo pulses; no auto-advance for 200 cycles.
//  5 power 1->0 at acoes=4 while press pending -> estado=00 and acoes=0 within 3 edges.
//    No passo; power 0->1 resumes from acoes=0.
//  6 press and advance tick forced same cycle -> estado=10, acoes unchanged, passo=0.
//    Async reset pulse mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/brinquedo_pkg.sv
// Shared codes for the dog toy action sequencer: FSM state codes, speed codes
// and the number of base ticks per advance at each speed.
package brinquedo_pkg;

    localparam logic [1:0] EST_DESLIGADO = 2'b00;
    localparam logic [1:0] EST_RODANDO   = 2'b01;
    localparam logic [1:0] EST_PAUSADO   = 2'b10;
    localparam logic [1:0] EST_MANUAL    = 2'b11;

    localparam logic [1:0] SPD_LENTA  = 2'b00;
    localparam logic [1:0] SPD_MEDIA  = 2'b01;
    localparam logic [1:0] SPD_RAPIDA = 2'b10;
    localparam logic [1:0] SPD_MANUAL = 2'b11;

    localparam int unsigned N_LENTA  = 4;
    localparam int unsigned N_MEDIA  = 2;
    localparam int unsigned N_RAPIDA = 1;

    localparam int unsigned NUM_ACOES_PADRAO = 6;
    localparam int unsigned PASSO_W          = 2;
    localparam int unsigned ACAO_W           = 3;

    // Terminal value of the step counter for a given speed code
    function automatic logic [PASSO_W-1:0] passo_final(input logic [1:0] spd);
        case (spd)
            SPD_LENTA: return PASSO_W'(N_LENTA - 1);
            SPD_MEDIA: return PASSO_W'(N_MEDIA - 1);
            default:   return PASSO_W'(N_RAPIDA - 1);
        endcase
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// single-cycle press event on an accepted 1->0 level change.
module debounce_botao #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clock_entrada,
    input  logic reset,
    input  logic botao_in,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             estavel_q, estavel_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample equal to the accepted level restarts the stability count
    always_comb begin
        s1_d      = botao_in;
        s2_d      = s1_q;
        estavel_d = estavel_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        if (s2_q == estavel_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_FIM) begin
            estavel_d = s2_q;
            cnt_d     = '0;
            press_d   = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_entrada or posedge reset) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            estavel_q <= 1'b0;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            estavel_q <= estavel_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/sequenciador_acoes.sv
// Action-index sequencer for the dog toy: synchronizes the switches, runs the
// base/step tick counters and the power/run/pause/manual FSM.
module sequenciador_acoes
    import brinquedo_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 50_000_000 / 8,
    parameter int unsigned NUM_ACOES       = NUM_ACOES_PADRAO,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clock_entrada,
    input  logic       reset,
    input  logic       power,
    input  logic       botao_in,
    input  logic       chave1,
    input  logic       chave2,
    output logic [2:0] acoes,
    output logic [1:0] velocidade,
    output logic [1:0] estado,
    output logic       passo
);

    localparam int unsigned BASE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [BASE_W-1:0] BASE_FIM = BASE_W'(TICK_DIV - 1);
    localparam logic [ACAO_W-1:0] ACAO_FIM = ACAO_W'(NUM_ACOES - 1);

    logic               power_s1_q, power_s1_d;
    logic               power_s2_q, power_s2_d;
    logic [1:0]         chave_s1_q, chave_s1_d;
    logic [1:0]         velocidade_q, velocidade_d;
    logic [1:0]         estado_q, estado_d;
    logic [ACAO_W-1:0]  acoes_q, acoes_d;
    logic               passo_q, passo_d;
    logic [BASE_W-1:0]  base_q, base_d;
    logic [PASSO_W-1:0] step_q, step_d;

    logic               press;
    logic               spd_chg;
    logic               base_tick;
    logic               step_fim;
    logic [ACAO_W-1:0]  acoes_prox;
    logic [BASE_W-1:0]  base_inc;

    debounce_botao #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock_entrada(clock_entrada),
        .reset        (reset),
        .botao_in     (botao_in),
        .press        (press)
    );

    // A speed change is acted on at the same edge velocidade takes its new value
    always_comb begin
        power_s1_d   = power;
        power_s2_d   = power_s1_q;
        chave_s1_d   = {chave2, chave1};
        velocidade_d = chave_s1_q;
        spd_chg      = (velocidade_d != velocidade_q);
        base_tick    = (base_q == BASE_FIM);
        step_fim     = (step_q == passo_final(velocidade_q));
        base_inc     = base_tick ? '0 : base_q + BASE_W'(1);
        acoes_prox   = (acoes_q == ACAO_FIM) ? '0 : acoes_q + ACAO_W'(1);
    end

    always_comb begin
        estado_d = estado_q;
        acoes_d  = acoes_q;
        base_d   = base_q;
        step_d   = step_q;
        passo_d  = 1'b0;
        if (!power_s2_q) begin
            estado_d = EST_DESLIGADO;
            acoes_d  = '0;
            base_d   = '0;
            step_d   = '0;
        end else begin
            case (estado_q)
                EST_DESLIGADO: begin
                    acoes_d  = '0;
                    base_d   = '0;
                    step_d   = '0;
                    estado_d = (velocidade_d == SPD_MANUAL) ? EST_MANUAL : EST_RODANDO;
                end
                EST_RODANDO: begin
                    if (spd_chg) begin
                        step_d = '0;
                        if (velocidade_d == SPD_MANUAL) begin
                            estado_d = EST_MANUAL;
                            base_d   = '0;
                        end else begin
                            base_d = base_inc;
                        end
                    end else if (press) begin
                        estado_d = EST_PAUSADO;
                    end else begin
                        base_d = base_inc;
                        if (base_tick) begin
                            if (step_fim) begin
                                step_d  = '0;
                                acoes_d = acoes_prox;
                                passo_d = 1'b1;
                            end else begin
                                step_d = step_q + PASSO_W'(1);
                            end
                        end
                    end
                end
                EST_PAUSADO: begin
                    if (spd_chg) begin
                        step_d = '0;
                    end else if (press) begin
                        // Resuming with the manual code parked goes straight to manual
                        if (velocidade_d == SPD_MANUAL) begin
                            estado_d = EST_MANUAL;
                            base_d   = '0;
                            step_d   = '0;
                        end else begin
                            estado_d = EST_RODANDO;
                        end
                    end
                end
                default: begin
                    base_d = '0;
                    step_d = '0;
                    if (spd_chg) begin
                        estado_d = EST_RODANDO;
                    end else if (press) begin
                        acoes_d = acoes_prox;
                        passo_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock_entrada or posedge reset) begin
        if (reset) begin
            power_s1_q   <= 1'b0;
            power_s2_q   <= 1'b0;
            chave_s1_q   <= 2'b00;
            velocidade_q <= 2'b00;
            estado_q     <= EST_DESLIGADO;
            acoes_q      <= '0;
            passo_q      <= 1'b0;
            base_q       <= '0;
            step_q       <= '0;
        end else begin
            power_s1_q   <= power_s1_d;
            power_s2_q   <= power_s2_d;
            chave_s1_q   <= chave_s1_d;
            velocidade_q <= velocidade_d;
            estado_q     <= estado_d;
            acoes_q      <= acoes_d;
            passo_q      <= passo_d;
            base_q       <= base_d;
            step_q       <= step_d;
        end
    end

    assign acoes      = acoes_q;
    assign velocidade = velocidade_q;
    assign estado     = estado_q;
    assign passo      = passo_q;

endmodule
